// File: rtl/vec_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_checker_pkg
// Description : Shared types and helpers for the vec_checker block.
//               - state_e    : checker sequencing states
//               - vec_width  : width of one stored {stim, expected} vector
//               - addr_width : vector-memory address width for a given depth
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package vec_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_APPLY   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam int DEF_IN_WIDTH  = 8;
  localparam int DEF_OUT_WIDTH = 8;
  localparam int DEF_DEPTH     = 16;

  function automatic int vec_width(input int in_w, input int out_w);
    return in_w + out_w;
  endfunction

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vec_mem.sv
`default_nettype none
// ============================================================================
// Module      : vec_mem
// Description : Simple dual-port vector RAM, one write port and one read
//               port with a registered output (1-cycle read latency).
// Ports       : clk, rst            - clock, async active-high reset (read reg)
//               wr_en/wr_addr/wr_data - write port
//               rd_addr / rd_data     - registered read port
// Revision    : 1.0 - initial release
// ============================================================================
module vec_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  // Storage is deliberately left unreset so it can map onto block RAM.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/vec_checker.sv
`default_nettype none
// ============================================================================
// Module      : vec_checker
// Description : Stimulus/response checker. Replays DEPTH stored vectors
//               {stim, expected} to a DUT, waits SETTLE cycles per vector and
//               compares the DUT response, reporting errors and first failure.
// Ports       : clk, rst                      - clock, async active-high reset
//               load_we/load_addr/load_data   - vector load (IDLE/DONE only)
//               num_vec, stop_on_err          - run configuration
//               start, abort                  - run control
//               stim / dut_resp               - DUT drive and response
//               busy, done, pass              - run status
//               err_count, fail_valid, fail_idx, fail_got - error reporting
//               vec_idx                       - current vector index
// Revision    : 1.0 - initial release
// ============================================================================
module vec_checker
  import vec_checker_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int SETTLE    = 1,
  parameter int ERR_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_we,
  input  logic [$clog2(DEPTH)-1:0]      load_addr,
  input  logic [IN_WIDTH+OUT_WIDTH-1:0] load_data,
  input  logic [$clog2(DEPTH):0]        num_vec,
  input  logic                          stop_on_err,
  input  logic                          start,
  input  logic                          abort,
  output logic [IN_WIDTH-1:0]           stim,
  input  logic [OUT_WIDTH-1:0]          dut_resp,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [ERR_WIDTH-1:0]          err_count,
  output logic                          fail_valid,
  output logic [$clog2(DEPTH)-1:0]      fail_idx,
  output logic [OUT_WIDTH-1:0]          fail_got,
  output logic [$clog2(DEPTH)-1:0]      vec_idx
);

  localparam int VEC_W  = vec_width(IN_WIDTH, OUT_WIDTH);
  localparam int ADDR_W = addr_width(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // Wait counter holds SETTLE-1 down to 0; width kept at least 1 bit so the
  // design still elaborates when SETTLE is 0 and WAIT is never entered.
  localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_e                state_q,      state_d;
  logic [CNT_W-1:0]      count_q,      count_d;
  logic [ADDR_W-1:0]     vec_idx_q,    vec_idx_d;
  logic [IN_WIDTH-1:0]   stim_q,       stim_d;
  logic [OUT_WIDTH-1:0]  exp_q,        exp_d;
  logic [ERR_WIDTH-1:0]  err_count_q,  err_count_d;
  logic                  fail_valid_q, fail_valid_d;
  logic [ADDR_W-1:0]     fail_idx_q,   fail_idx_d;
  logic [OUT_WIDTH-1:0]  fail_got_q,   fail_got_d;
  logic                  busy_q,       busy_d;
  logic                  done_q,       done_d;
  logic                  pass_q,       pass_d;
  logic [WAIT_W-1:0]     wait_q,       wait_d;

  logic [VEC_W-1:0]      rd_data;
  logic                  mismatch;
  logic                  last_vec;

  // Writes are gated so the vector table cannot change under a running test.
  vec_mem #(
    .WIDTH (VEC_W),
    .DEPTH (DEPTH)
  ) u_vec_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (load_we && !busy_q),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (vec_idx_q),
    .rd_data (rd_data)
  );

  assign last_vec = (({1'b0, vec_idx_q} + CNT_ONE) == count_q);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    vec_idx_d    = vec_idx_q;
    stim_d       = stim_q;
    exp_d        = exp_q;
    err_count_d  = err_count_q;
    fail_valid_d = fail_valid_q;
    fail_idx_d   = fail_idx_q;
    fail_got_d   = fail_got_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    wait_d       = wait_q;
    mismatch     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_count_d  = '0;
          fail_valid_d = 1'b0;
          fail_idx_d   = '0;
          fail_got_d   = '0;
          vec_idx_d    = '0;
          count_d      = (num_vec > DEPTH_CNT) ? DEPTH_CNT : num_vec;
          if (count_d == '0) begin
            // Empty run completes immediately as a trivial pass.
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end
      end

      ST_FETCH: begin
        state_d = ST_APPLY;
      end

      ST_APPLY: begin
        stim_d = rd_data[VEC_W-1:OUT_WIDTH];
        exp_d  = rd_data[OUT_WIDTH-1:0];
        if (SETTLE > 0) begin
          state_d = ST_WAIT;
          wait_d  = WAIT_INIT;
        end else begin
          state_d = ST_COMPARE;
        end
      end

      ST_WAIT: begin
        if (wait_q == '0) begin
          state_d = ST_COMPARE;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end

      ST_COMPARE: begin
        mismatch = (dut_resp != exp_q);
        if (mismatch) begin
          if (err_count_q != '1) begin
            err_count_d = err_count_q + ERR_WIDTH'(1);
          end
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_idx_d   = vec_idx_q;
            fail_got_d   = dut_resp;
          end
        end
        if (last_vec || (stop_on_err && mismatch)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == '0);
        end else begin
          vec_idx_d = vec_idx_q + ADDR_W'(1);
          state_d   = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort overrides everything else this cycle; debug state is preserved.
    if (abort) begin
      state_d      = ST_IDLE;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      pass_d       = 1'b0;
      count_d      = count_q;
      vec_idx_d    = vec_idx_q;
      stim_d       = stim_q;
      exp_d        = exp_q;
      err_count_d  = err_count_q;
      fail_valid_d = fail_valid_q;
      fail_idx_d   = fail_idx_q;
      fail_got_d   = fail_got_q;
      wait_d       = wait_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      vec_idx_q    <= '0;
      stim_q       <= '0;
      exp_q        <= '0;
      err_count_q  <= '0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
      fail_got_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      vec_idx_q    <= vec_idx_d;
      stim_q       <= stim_d;
      exp_q        <= exp_d;
      err_count_q  <= err_count_d;
      fail_valid_q <= fail_valid_d;
      fail_idx_q   <= fail_idx_d;
      fail_got_q   <= fail_got_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      wait_q       <= wait_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_valid = fail_valid_q;
  assign fail_idx   = fail_idx_q;
  assign fail_got   = fail_got_q;
  assign vec_idx    = vec_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vec_checker
// Description : Self-checking bench for vec_checker. The attached DUT model
//               is dut_resp = ~stim; expected run outcomes come from a
//               vector-list reference model kept in the bench.
// Ports       : none (top-level bench)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_checker;

  localparam int IN_W   = 8;
  localparam int OUT_W  = 8;
  localparam int DEPTH  = 16;
  localparam int SETTLE = 1;
  localparam int ERR_W  = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               load_we = 1'b0;
  logic [3:0]         load_addr = '0;
  logic [15:0]        load_data = '0;
  logic [4:0]         num_vec = '0;
  logic               stop_on_err = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [IN_W-1:0]    stim;
  logic [OUT_W-1:0]   dut_resp;
  logic               busy, done, pass, fail_valid;
  logic [ERR_W-1:0]   err_count;
  logic [3:0]         fail_idx, vec_idx;
  logic [OUT_W-1:0]   fail_got;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: stored vectors and last stimulus driven out.
  logic [7:0] m_stim [DEPTH];
  logic [7:0] m_exp  [DEPTH];
  logic [7:0] m_last_stim = 8'h00;

  always #5 clk = ~clk;

  assign dut_resp = ~stim;

  vec_checker #(
    .IN_WIDTH  (IN_W),
    .OUT_WIDTH (OUT_W),
    .DEPTH     (DEPTH),
    .SETTLE    (SETTLE),
    .ERR_WIDTH (ERR_W)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .num_vec     (num_vec),
    .stop_on_err (stop_on_err),
    .start       (start),
    .abort       (abort),
    .stim        (stim),
    .dut_resp    (dut_resp),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .fail_valid  (fail_valid),
    .fail_idx    (fail_idx),
    .fail_got    (fail_got),
    .vec_idx     (vec_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [7:0] s, input logic [7:0] e);
    load_we   = 1'b1;
    load_addr = 4'(a);
    load_data = {s, e};
    m_stim[a] = s;
    m_exp[a]  = e;
    tick();
    load_we   = 1'b0;
  endtask

  // Runs one test and compares every reported result with the model.
  task automatic run_vec(input int num, input bit stop, input string tag);
    int         cnt, errs, first, n_done, lat, cyc;
    logic [7:0] resp, got_first;
    bit         mm;
    cnt = (num > DEPTH) ? DEPTH : num;
    errs = 0; first = -1; n_done = 0; got_first = 8'h00;
    for (int i = 0; i < cnt; i++) begin
      n_done      = i + 1;
      m_last_stim = m_stim[i];
      resp        = ~m_stim[i];
      mm          = (resp != m_exp[i]);
      if (mm) begin
        errs++;
        if (first < 0) begin
          first     = i;
          got_first = resp;
        end
      end
      if (mm && stop) break;
    end
    lat = (cnt == 0) ? 0 : n_done * (SETTLE + 3);

    num_vec     = 5'(num);
    stop_on_err = stop;
    start       = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".busy_start"}, 32'(busy), (cnt == 0) ? 32'd0 : 32'd1);
    cyc = 0;
    while (!done && cyc < 1000) begin
      tick();
      cyc++;
    end
    check({tag, ".latency"},    32'(cyc),        32'(lat));
    check({tag, ".done"},       32'(done),       32'd1);
    check({tag, ".busy_end"},   32'(busy),       32'd0);
    check({tag, ".pass"},       32'(pass),       (errs == 0) ? 32'd1 : 32'd0);
    check({tag, ".err_count"},  32'(err_count),  32'(errs));
    check({tag, ".fail_valid"}, 32'(fail_valid), (first >= 0) ? 32'd1 : 32'd0);
    check({tag, ".fail_idx"},   32'(fail_idx),   (first >= 0) ? 32'(first) : 32'd0);
    check({tag, ".fail_got"},   32'(fail_got),   32'(got_first));
    check({tag, ".vec_idx"},    32'(vec_idx),    (n_done > 0) ? 32'(n_done - 1) : 32'd0);
    check({tag, ".stim"},       32'(stim),       32'(m_last_stim));
  endtask

  task automatic load_basic();
    load(0, 8'h0F, 8'hF0);
    load(1, 8'hAA, 8'h55);
    load(2, 8'h00, 8'hFF);
    load(3, 8'h3C, 8'hC3);
  endtask

  initial begin
    logic [7:0] s, e;
    int         c;

    // Reset state
    repeat (3) tick();
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    check("rst.stim",       32'(stim),       32'd0);
    check("rst.pass",       32'(pass),       32'd0);
    check("rst.err_count",  32'(err_count),  32'd0);
    check("rst.fail_valid", 32'(fail_valid), 32'd0);
    check("rst.vec_idx",    32'(vec_idx),    32'd0);

    // Directed runs
    load_basic();
    run_vec(4, 1'b0, "allpass");
    load(1, 8'hAA, 8'h54);
    run_vec(4, 1'b0, "cont_err");
    run_vec(4, 1'b1, "stop_err");
    run_vec(0, 1'b0, "zero");
    for (int i = 4; i < DEPTH; i++) begin
      s = 8'($urandom);
      load(i, s, ~s);
    end
    run_vec(20, 1'b0, "clamp20");

    // Abort in WAIT of vector 2, with ignored start/load while busy
    num_vec     = 5'd4;
    stop_on_err = 1'b0;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (c = 1; c <= 10; c++) begin
      tick();
      if (c == 3) begin
        start     = 1'b1;
        load_we   = 1'b1;
        load_addr = 4'd0;
        load_data = 16'h0F00;
      end else begin
        start   = 1'b0;
        load_we = 1'b0;
      end
    end
    check("abort.busy_before", 32'(busy),    32'd1);
    check("abort.vec_idx",     32'(vec_idx), 32'd2);
    check("abort.stim_before", 32'(stim),    32'(m_stim[2]));
    m_last_stim = m_stim[2];
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort.busy",       32'(busy),       32'd0);
    check("abort.done",       32'(done),       32'd0);
    check("abort.pass",       32'(pass),       32'd0);
    check("abort.err_count",  32'(err_count),  32'd1);
    check("abort.fail_valid", 32'(fail_valid), 32'd1);
    check("abort.fail_idx",   32'(fail_idx),   32'd1);
    check("abort.fail_got",   32'(fail_got),   32'h55);
    check("abort.stim",       32'(stim),       32'(m_last_stim));
    tick();
    check("abort.idle_stays", 32'(busy), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort.busy", 32'(busy), 32'd0);
    check("start_abort.done", 32'(done), 32'd0);
    run_vec(1, 1'b0, "mem_intact");

    // Asynchronous reset in COMPARE of vector 0
    load(1, 8'hAA, 8'h55);
    num_vec = 5'd4;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("arst.busy",       32'(busy),       32'd0);
    check("arst.done",       32'(done),       32'd0);
    check("arst.stim",       32'(stim),       32'd0);
    check("arst.vec_idx",    32'(vec_idx),    32'd0);
    check("arst.err_count",  32'(err_count),  32'd0);
    check("arst.fail_valid", 32'(fail_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_last_stim = 8'h00;
    tick();
    load_basic();
    run_vec(4, 1'b0, "after_rst");

    // Randomized runs
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        s = 8'($urandom);
        e = ~s;
        if ($urandom_range(0, 3) == 0) e = e ^ (8'h01 << $urandom_range(0, 7));
        load(i, s, e);
      end
      run_vec(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
